// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: ALU and load results each wait in a small FIFO. A round-robin
// arbiter drains them into one registered register-file write port and tracks pending writes.
module regfile_wb_queue #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] in_reg,
  input  logic [DATA_W-1:0] in_data,
  output logic              ready,
  output logic              nempty,
  output logic [ADDR_W-1:0] head_reg,
  output logic [DATA_W-1:0] head_data,
  output logic [31:0]       pend
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][ADDR_W-1:0] regs;
  logic [DEPTH-1:0][DATA_W-1:0] data;
  logic [PW-1:0]                rd_ptr, wr_ptr;
  logic [CW-1:0]                count;

  // Ready looks only at state, so a full queue never accepts while it drains.
  assign ready     = rst_n & ~flush & (count != CW'(DEPTH));
  assign nempty    = (count != '0);
  assign head_reg  = regs[rd_ptr];
  assign head_data = data[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '0;
      data <= '0;
    end else if (push) begin
      regs[wr_ptr] <= in_reg;
      data[wr_ptr] <= in_data;
    end
  end

  // An entry is live when its distance from the head is below the count.
  always_comb begin
    pend = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ({1'b0, PW'(i) - rd_ptr} < count) pend = pend | (32'd1 << regs[i]);
    end
  end
endmodule

module regfile_wb_arbiter #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_reg,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_reg,
  input  logic [DATA_W-1:0] mem_data,
  output logic              regWrite,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic [31:0]       pending
);
  logic [1:0]             valid, ready, push, nempty, grant;
  logic [1:0][ADDR_W-1:0] in_reg, head_reg;
  logic [1:0][DATA_W-1:0] in_data, head_data;
  logic [1:0][31:0]       pend;
  logic                   last_mem, sel;

  assign valid   = {mem_valid, alu_valid};
  assign in_reg  = {mem_reg, alu_reg};
  assign in_data = {mem_data, alu_data};
  assign push    = valid & ready;
  assign alu_ready = ready[0];
  assign mem_ready = ready[1];

  for (genvar i = 0; i < 2; i++) begin : g_q
    regfile_wb_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_q (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .push     (push[i]),
      .pop      (grant[i]),
      .in_reg   (in_reg[i]),
      .in_data  (in_data[i]),
      .ready    (ready[i]),
      .nempty   (nempty[i]),
      .head_reg (head_reg[i]),
      .head_data(head_data[i]),
      .pend     (pend[i])
    );
  end

  // Index 0 = ALU, 1 = MEM; on a tie the source not granted last wins.
  always_comb begin
    grant = '0;
    if (!flush) begin
      if (nempty[0] && (!nempty[1] || last_mem)) grant[0] = 1'b1;
      else if (nempty[1])                        grant[1] = 1'b1;
    end
  end
  assign sel = grant[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_mem   <= 1'b1;
      regWrite   <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
    end else begin
      regWrite <= 1'b0;
      if (|grant) begin
        last_mem   <= sel;
        regWrite   <= (head_reg[sel] != '0);
        write_reg  <= head_reg[sel];
        write_data <= head_data[sel];
      end
    end
  end

  always_comb begin
    pending = pend[0] | pend[1];
    if (regWrite) pending = pending | (32'd1 << write_reg);
    pending[0] = 1'b0;
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, single writes, r0, round-robin
// streaming with backpressure, flush, and async reset with queued entries.
module tb_regfile_wb_arbiter;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic              alu_valid = 1'b0, mem_valid = 1'b0;
  logic [ADDR_W-1:0] alu_reg = '0, mem_reg = '0;
  logic [DATA_W-1:0] alu_data = '0, mem_data = '0;
  logic              alu_ready, mem_ready, regWrite;
  logic [ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0] write_data;
  logic [31:0]       pending;
  int tests = 0, fails = 0;
  int ai, mi;
  logic exp_ar, exp_mr;

  regfile_wb_arbiter #(.DEPTH(2), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_reg(mem_reg), .mem_data(mem_data),
    .regWrite(regWrite), .write_reg(write_reg), .write_data(write_data), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // reset state
    nxt; nxt;
    chk("rst_regWrite", 32'(regWrite), 0);
    chk("rst_pending", pending, 0);
    chk("rst_alu_ready", 32'(alu_ready), 0);
    chk("rst_mem_ready", 32'(mem_ready), 0);
    chk("rst_write_reg", 32'(write_reg), 0);
    chk("rst_write_data", write_data, 0);
    rst_n = 1'b1; #1;
    chk("rel_alu_ready", 32'(alu_ready), 1);
    chk("rel_mem_ready", 32'(mem_ready), 1);

    // single ALU write r5
    alu_valid = 1'b1; alu_reg = 5; alu_data = 32'hDEADBEEF;
    nxt; alu_valid = 1'b0;
    chk("t2_pend_set", pending, 32'h20);
    chk("t2_no_early", 32'(regWrite), 0);
    nxt;
    chk("t2_regWrite", 32'(regWrite), 1);
    chk("t2_write_reg", 32'(write_reg), 5);
    chk("t2_write_data", write_data, 32'hDEADBEEF);
    chk("t2_pend_out", pending, 32'h20);
    nxt;
    chk("t2_one_pulse", 32'(regWrite), 0);
    chk("t2_pend_clr", pending, 0);
    chk("t2_data_hold", write_data, 32'hDEADBEEF);

    // load to r0: consumed, never written
    mem_valid = 1'b1; mem_reg = 0; mem_data = 32'h1234;
    chk("t5_ready", 32'(mem_ready), 1);
    nxt; mem_valid = 1'b0;
    chk("t5_pend0_a", pending, 0);
    chk("t5_regWrite_a", 32'(regWrite), 0);
    chk("t5_ready_a", 32'(mem_ready), 1);
    nxt;
    chk("t5_regWrite_b", 32'(regWrite), 0);
    chk("t5_pend0_b", pending, 0);
    chk("t5_data", write_data, 32'h1234);
    nxt;
    chk("t5_regWrite_c", 32'(regWrite), 0);

    // both sources streaming: alternating grants, readies alternate once full
    ai = 0; mi = 0;
    for (int k = 1; k <= 10; k++) begin
      exp_ar = (k <= 2) || (k % 2 == 1);
      exp_mr = (k <= 2) || (k % 2 == 0);
      alu_valid = 1'b1; alu_reg = ADDR_W'(2 * ai + 1); alu_data = 32'hA0000000 + 32'(2 * ai + 1);
      mem_valid = 1'b1; mem_reg = ADDR_W'(2 * mi + 2); mem_data = 32'hB0000000 + 32'(2 * mi + 2);
      chk("rr_alu_ready", 32'(alu_ready), 32'(exp_ar));
      chk("rr_mem_ready", 32'(mem_ready), 32'(exp_mr));
      if (exp_ar) ai++;
      if (exp_mr) mi++;
      nxt;
      if (k >= 2) begin
        chk("rr_regWrite", 32'(regWrite), 1);
        chk("rr_write_reg", 32'(write_reg), 32'(k - 1));
        chk("rr_write_data", write_data, (((k - 1) % 2) ? 32'hA0000000 : 32'hB0000000) + 32'(k - 1));
      end else begin
        chk("rr_first_idle", 32'(regWrite), 0);
      end
    end
    alu_valid = 1'b0; mem_valid = 1'b0;
    for (int k = 11; k <= 13; k++) begin
      nxt;
      chk("drain_regWrite", 32'(regWrite), 1);
      chk("drain_write_reg", 32'(write_reg), 32'(k - 1));
      chk("drain_write_data", write_data, ((k % 2) ? 32'hB0000000 : 32'hA0000000) + 32'(k - 1));
    end
    chk("drain_pend_last", pending, 32'h1000);
    nxt;
    chk("drain_idle", 32'(regWrite), 0);
    chk("drain_pend_clr", pending, 0);

    // flush with three writes in flight
    alu_valid = 1'b1; alu_reg = 20; alu_data = 32'hC0000014;
    mem_valid = 1'b1; mem_reg = 21; mem_data = 32'hC0000015;
    nxt; alu_reg = 22; alu_data = 32'hC0000016; mem_valid = 1'b0;
    nxt;
    chk("fl_regWrite_pre", 32'(regWrite), 1);
    chk("fl_write_reg_pre", 32'(write_reg), 20);
    chk("fl_pend_pre", pending, 32'h00700000);
    flush = 1'b1; alu_reg = 23; alu_data = 32'hC0000017; #1;
    chk("fl_alu_ready", 32'(alu_ready), 0);
    chk("fl_mem_ready", 32'(mem_ready), 0);
    nxt; flush = 1'b0; alu_valid = 1'b0;
    chk("fl_regWrite_a", 32'(regWrite), 0);
    chk("fl_pend_a", pending, 0);
    nxt;
    chk("fl_regWrite_b", 32'(regWrite), 0);
    chk("fl_pend_b", pending, 0);
    chk("fl_write_reg_hold", 32'(write_reg), 20);

    // async reset with two entries queued
    alu_valid = 1'b1; alu_reg = 7; alu_data = 32'h7;
    mem_valid = 1'b1; mem_reg = 8; mem_data = 32'h8;
    nxt; alu_valid = 1'b0; mem_valid = 1'b0;
    chk("ar_pend_pre", pending, 32'h180);
    #2 rst_n = 1'b0; #1;
    chk("ar_regWrite", 32'(regWrite), 0);
    chk("ar_pending", pending, 0);
    chk("ar_alu_ready", 32'(alu_ready), 0);
    chk("ar_mem_ready", 32'(mem_ready), 0);
    nxt; rst_n = 1'b1; #1;
    chk("ar_rel_alu_ready", 32'(alu_ready), 1);
    chk("ar_rel_mem_ready", 32'(mem_ready), 1);
    for (int k = 0; k < 4; k++) begin
      nxt;
      chk("ar_no_write", 32'(regWrite), 0);
      chk("ar_no_pend", pending, 0);
    end

    // reset pointer favours ALU on the first tie
    alu_valid = 1'b1; alu_reg = 9;  alu_data = 32'h9;
    mem_valid = 1'b1; mem_reg = 10; mem_data = 32'hA;
    nxt; alu_valid = 1'b0; mem_valid = 1'b0;
    nxt;
    chk("tie_first", 32'(write_reg), 9);
    nxt;
    chk("tie_second", 32'(write_reg), 10);
    chk("tie_second_we", 32'(regWrite), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
